// File: rtl/x_ibufds_bus_filter.sv
// Multi-channel differential receiver: per-pin synchroniser, pair decode, glitch filter, invalid-pair fault flags (X_IBUFDS_BUS_ERRCNT_EN adds ERR_CNT).
// Pin-to-O latency SYNC_STAGES+FILT_LEN edges; no backpressure, every channel takes one sample per clock.
module x_ibufds_bus_filter #(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter int   INV_LIMIT   = 16,
    parameter logic INIT_O      = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] IB,
    input  logic             FAULT_CLR,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] VALID,
    output logic [WIDTH-1:0] FAULT
`ifdef X_IBUFDS_BUS_ERRCNT_EN
    ,
    output logic [15:0]      ERR_CNT
`endif
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int IW = $clog2(INV_LIMIT + 1);
    localparam logic [FW-1:0] FLT_TOP = FW'(FILT_LEN - 1);
    localparam logic [FW-1:0] OK_MAX  = FW'(FILT_LEN);
    localparam logic [IW-1:0] INV_MAX = IW'(INV_LIMIT);
    localparam logic [IW-1:0] INV_PRE = IW'(INV_LIMIT - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] i_sync_q, ib_sync_q;

    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] fault_q, fault_d;

    logic [WIDTH-1:0][FW-1:0] flt_cnt_q, flt_cnt_d;
    logic [WIDTH-1:0][FW-1:0] ok_cnt_q, ok_cnt_d;
    logic [WIDTH-1:0][IW-1:0] inv_cnt_q, inv_cnt_d;

    logic [WIDTH-1:0] s_i;
    logic [WIDTH-1:0] s_ok;

    assign s_i  = i_sync_q[SYNC_STAGES-1];
    assign s_ok = i_sync_q[SYNC_STAGES-1] ^ ib_sync_q[SYNC_STAGES-1];

    // Legs reset to opposite levels so the first post-reset samples decode valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            i_sync_q  <= {SYNC_STAGES{{WIDTH{INIT_O}}}};
            ib_sync_q <= {SYNC_STAGES{{WIDTH{~INIT_O}}}};
        end else begin
            i_sync_q  <= {i_sync_q[SYNC_STAGES-2:0], I};
            ib_sync_q <= {ib_sync_q[SYNC_STAGES-2:0], IB};
        end
    end

    always_comb begin
        o_d       = o_q;
        valid_d   = '0;
        fault_d   = fault_q & ~{WIDTH{FAULT_CLR}};
        flt_cnt_d = '0;
        ok_cnt_d  = '0;
        inv_cnt_d = '0;
        for (int c = 0; c < WIDTH; c++) begin
            if (s_ok[c]) begin
                ok_cnt_d[c] = (ok_cnt_q[c] == OK_MAX) ? OK_MAX : ok_cnt_q[c] + 1'b1;
                if (s_i[c] != o_q[c]) begin
                    if (flt_cnt_q[c] == FLT_TOP) begin
                        o_d[c] = s_i[c];
                    end else begin
                        flt_cnt_d[c] = flt_cnt_q[c] + 1'b1;
                    end
                end
            end else begin
                inv_cnt_d[c] = (inv_cnt_q[c] == INV_MAX) ? INV_MAX : inv_cnt_q[c] + 1'b1;
                // Only the transition into the limit sets FAULT, so a clear sticks while the pair stays bad.
                if (inv_cnt_q[c] == INV_PRE) begin
                    fault_d[c] = 1'b1;
                end
            end
            valid_d[c] = (ok_cnt_d[c] == OK_MAX);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_q       <= {WIDTH{INIT_O}};
            valid_q   <= '0;
            fault_q   <= '0;
            flt_cnt_q <= '0;
            ok_cnt_q  <= '0;
            inv_cnt_q <= '0;
        end else begin
            o_q       <= o_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            flt_cnt_q <= flt_cnt_d;
            ok_cnt_q  <= ok_cnt_d;
            inv_cnt_q <= inv_cnt_d;
        end
    end

    assign O     = o_q;
    assign VALID = valid_q;
    assign FAULT = fault_q;

`ifdef X_IBUFDS_BUS_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        fault_rise;

    assign fault_rise = |(fault_d & ~fault_q);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (FAULT_CLR) begin
            err_cnt_d = {15'd0, fault_rise};
        end else if (fault_rise && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_x_ibufds_bus_filter.sv
// Directed bench for x_ibufds_bus_filter with a sliding-window reference model checked every cycle.
// Inputs change 1 time unit after a rising edge; outputs are read at the falling edge and 1 unit after the rising edge.
module tb_x_ibufds_bus_filter;

    localparam int W = 8;
    localparam int F = 4;
    localparam int L = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] i_pin;
    logic [W-1:0] ib_pin;
    logic         fault_clr;
    logic [W-1:0] o;
    logic [W-1:0] valid;
    logic [W-1:0] fault;
`ifdef X_IBUFDS_BUS_ERRCNT_EN
    logic [15:0]  err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    x_ibufds_bus_filter #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .FILT_LEN   (F),
        .INV_LIMIT  (L),
        .INIT_O     (1'b0)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .I        (i_pin),
        .IB       (ib_pin),
        .FAULT_CLR(fault_clr),
        .O        (o),
        .VALID    (valid),
        .FAULT    (fault)
`ifdef X_IBUFDS_BUS_ERRCNT_EN
        ,
        .ERR_CNT  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: O, VALID and FAULT derived from a window of recent post-sync samples.
    logic [W-1:0] sy_i [2];
    logic [W-1:0] sy_ib[2];
    logic [W-1:0] h_ok [$];
    logic [W-1:0] h_val[$];
    logic [W-1:0] m_o, m_valid, m_fault;
    logic [15:0]  m_err;
    bit           model_on = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] s_i, s_ib, f_new, rose;
        bit all_ok, all_one, all_zero, all_bad;
        if (rst) begin
            sy_i[0] = '0;  sy_i[1] = '0;
            sy_ib[0] = '1; sy_ib[1] = '1;
            h_ok.delete();
            h_val.delete();
            m_o = '0; m_valid = '0; m_fault = '0; m_err = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            s_i  = sy_i[1];
            s_ib = sy_ib[1];
            sy_i[1]  = sy_i[0];  sy_i[0]  = i_pin;
            sy_ib[1] = sy_ib[0]; sy_ib[0] = ib_pin;
            h_ok.push_front(s_i ^ s_ib);
            h_val.push_front(s_i);
            if (h_ok.size() > L + 1) begin
                void'(h_ok.pop_back());
                void'(h_val.pop_back());
            end
            f_new = m_fault & ~{W{fault_clr}};
            for (int c = 0; c < W; c++) begin
                all_ok   = (h_ok.size() >= F);
                all_one  = 1'b1;
                all_zero = 1'b1;
                for (int k = 0; k < F && k < h_ok.size(); k++) begin
                    all_ok   = all_ok & h_ok[k][c];
                    all_one  = all_one & h_val[k][c];
                    all_zero = all_zero & ~h_val[k][c];
                end
                m_valid[c] = all_ok;
                if (all_ok && all_one)  m_o[c] = 1'b1;
                if (all_ok && all_zero) m_o[c] = 1'b0;
                all_bad = (h_ok.size() >= L);
                for (int k = 0; k < L && k < h_ok.size(); k++) begin
                    all_bad = all_bad & ~h_ok[k][c];
                end
                if (all_bad && (h_ok.size() == L || h_ok[L][c])) f_new[c] = 1'b1;
            end
            rose = f_new & ~m_fault;
            if (fault_clr)                        m_err = (rose != '0) ? 16'd1 : 16'd0;
            else if (rose != '0 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            m_fault = f_new;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_O", o, m_o);
            check("cyc_VALID", valid, m_valid);
            check("cyc_FAULT", fault, m_fault);
`ifdef X_IBUFDS_BUS_ERRCNT_EN
            check("cyc_ERR_CNT", err_cnt, m_err);
`endif
        end
    end

    initial begin
        rst = 1'b1; i_pin = 8'h00; ib_pin = 8'hFF; fault_clr = 1'b0;
        repeat (3) step();
        check("rst_O", o, 8'h00);
        check("rst_VALID", valid, 8'h00);
        check("rst_FAULT", fault, 8'h00);
`ifdef X_IBUFDS_BUS_ERRCNT_EN
        check("rst_ERR_CNT", err_cnt, 16'd0);
`endif
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("valid_ramp", valid, 8'h00);
        end
        step();
        check("valid_full", valid, 8'hFF);
        check("valid_full_O", o, 8'h00);

        // ch0 clean edge: O[0] must rise exactly 6 edges later
        i_pin[0] = 1'b1; ib_pin[0] = 1'b0;
        repeat (5) step();
        check("ch0_t5", o, 8'h00);
        step();
        check("ch0_t6", o, 8'h01);
        check("ch0_valid", valid, 8'hFF);

        // ch1 3-cycle glitch is swallowed
        i_pin[1] = 1'b1; ib_pin[1] = 1'b0;
        repeat (3) step();
        i_pin[1] = 1'b0; ib_pin[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("ch1_O", {15'd0, o[1]}, 16'd0);
            check("ch1_VALID", {15'd0, valid[1]}, 16'd1);
        end

        // ch2 held 11 for 16 cycles
        i_pin[2] = 1'b1; ib_pin[2] = 1'b1;
        repeat (16) step();
        i_pin[2] = 1'b0; ib_pin[2] = 1'b1;
        step();
        check("ch2_fault_t17", fault, 8'h00);
        step();
        check("ch2_fault_t18", fault, 8'h04);
        check("ch2_O_held", o, 8'h01);
        check("ch2_valid", valid, 8'hFB);
`ifdef X_IBUFDS_BUS_ERRCNT_EN
        check("ch2_err", err_cnt, 16'd1);
`endif
        repeat (3) step();
        check("ch2_sticky", fault, 8'h04);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("ch2_cleared", fault, 8'h00);
`ifdef X_IBUFDS_BUS_ERRCNT_EN
        check("ch2_err_clr", err_cnt, 16'd0);
`endif

        // ch3 fault lands on the same edge as FAULT_CLR
        i_pin[3] = 1'b0; ib_pin[3] = 1'b0;
        repeat (16) step();
        i_pin[3] = 1'b0; ib_pin[3] = 1'b1;
        step();
        check("ch3_pre", fault, 8'h00);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("ch3_set_wins", fault, 8'h08);
`ifdef X_IBUFDS_BUS_ERRCNT_EN
        check("ch3_err", err_cnt, 16'd1);
`endif
        step();
        check("ch3_sticky", fault, 8'h08);

        // ch0 back to 0, then reset while a rise is part-way through the filter
        i_pin[0] = 1'b0; ib_pin[0] = 1'b1;
        repeat (8) step();
        check("ch0_fall", o, 8'h00);
        i_pin[0] = 1'b1; ib_pin[0] = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_O", o, 8'h00);
        check("mid_rst_FAULT", fault, 8'h00);
        check("mid_rst_VALID", valid, 8'h00);
        repeat (5) step();
        check("post_rst_t5", o, 8'h00);
        step();
        check("post_rst_t6", o, 8'h01);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
